program_run_checker: RTL
========================

# program_run_checker

Synthesizable run-and-check controller that generalises the processor testbench flow into hardware: it holds the processor in reset, releases it for a programmable number of cycles, then scans the general-purpose register file one entry per cycle and compares each against an expected-value store. Register width, register count, first checked index, and cycle budget are parameters. It reports pass/fail, the first mismatch (index, actual, expected) and a mismatch count, with an optional stop-on-first-mismatch mode. It sits beside `Processor`, driving its reset and observing `gpr` through a read port.

## Interface

- `WIDTH`, 32, register data width
- `NREGS`, 32, register count; indices `0..NREGS-1`
- `FIRST_REG`, 1, lowest index checked (register 0 excluded by default)
- `CW`, 16, width of the run-cycle count
- `RESET_CYCLES`, 2, cycles `proc_reset` is held in the RESET state (≥1)
- Derived: `IW = $clog2(NREGS)`
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low; low forces IDLE immediately
- `start`  in  1  one-cycle start pulse; honoured only in IDLE or DONE
- `run_cycles`  in  CW  processor run length; sampled on accepted `start`
- `stop_on_first`  in  1  mode; sampled on accepted `start`
- `proc_reset`  out  1  active-high reset to `Processor`
- `rf_addr`  out  IW  register-file read address
- `rf_data`  in  WIDTH  register-file read data, combinational from `rf_addr`
- `exp_addr`  out  IW  expected-store address, always equal to `rf_addr`
- `exp_data`  in  WIDTH  expected value, combinational from `exp_addr`
- `busy`  out  1  high in RESET, RUN, SCAN
- `done`  out  1  high in DONE
- `pass`  out  1  valid when `done`; 1 iff `mismatch_count == 0`
- `fail_idx`  out  IW  index of first mismatch
- `fail_actual`  out  WIDTH  `rf_data` at first mismatch
- `fail_expected`  out  WIDTH  `exp_data` at first mismatch
- `mismatch_count`  out  IW+1  number of mismatching registers

## Operation

- States: IDLE, RESET, RUN, SCAN, DONE.
- IDLE: `proc_reset=1`. On `start`, go to RESET, latch `run_cycles` and `stop_on_first`, clear all result registers.
- RESET: `proc_reset=1` for exactly `RESET_CYCLES` cycles, then RUN, or SCAN directly if the latched `run_cycles == 0`.
- RUN: `proc_reset=0` for exactly the latched `run_cycles` cycles, then SCAN.
- SCAN: `proc_reset=1`. Processor reset clears only PC; GPR contents are preserved. Index starts at `FIRST_REG` and increments by one each cycle. Each cycle compares `rf_data != exp_data`:
  - On the first mismatch, capture `fail_idx`, `fail_actual` and `fail_expected`.
  - Every mismatch increments `mismatch_count`.
- SCAN ends after index `NREGS-1`, or, when `stop_on_first=1`, in the cycle after the first mismatch is registered. Then go to DONE.
- DONE: results held stable and `proc_reset=1`. `start` restarts from RESET with results cleared on entry.
- `start` in RESET, RUN or SCAN is ignored.
- `rf_addr` outside SCAN: `FIRST_REG`.

## Timing

- Reset values: `proc_reset=1`, `busy=0`, `done=0`, `pass=0`, `fail_idx=0`, `fail_actual=0`, `fail_expected=0`, `mismatch_count=0`, `rf_addr=FIRST_REG`.
- With `start` at edge 0: RESET occupies cycles 1..R, where R = `RESET_CYCLES`.
- RUN occupies the next N cycles, where N = latched `run_cycles`.
- SCAN (full) occupies `NREGS-FIRST_REG` cycles.
- `done` rises on the following edge. Total from `start` to `done` is `1+R+N+(NREGS-FIRST_REG)` cycles.
- Comparison is combinational within the SCAN cycle; results are registered at that cycle's end.
- `reset` low mid-operation: outputs go to reset values asynchronously, and `proc_reset` is asserted immediately.
- Counting is `run_cycles` modulo 2^CW. The max value 2^CW-1 must not wrap to 0.

## Structure

- Shared header `sysarch_defs.vh`: state encodings (3-bit localparams `S_IDLE`..`S_DONE`).
- One sub-module, `cycle_counter` (parametrised width, load/decrement/zero flag), reused for the RESET and RUN phases.
- Scan index and result capture live in the top level.

## Test plan

- Expected equals actual for regs 1..31, `run_cycles=20`, R=2 → `done` 54 cycles after `start`, `pass=1`, `mismatch_count=0`, `proc_reset` low exactly 20 cycles.
- Reg 5 actual `0xcafebabe`, expected `0x00000008`, reg 9 also wrong, `stop_on_first=0` → `fail_idx=5`, `fail_actual=0xcafebabe`, `fail_expected=0x8`, `mismatch_count=2`, `pass=0`.
- Same data, `stop_on_first=1` → `done` asserted 5 cycles after SCAN entry, `mismatch_count=1`, `fail_idx=5`.
- `run_cycles=0` → RESET goes straight to SCAN, and `proc_reset` never deasserts.
- `start` pulsed during RUN is ignored. `reset` pulled low mid-SCAN → immediate reset values, and a subsequent `start` yields a fresh correct result.
- `start` in DONE with new data → results cleared on entering RESET, then a new correct verdict.

Source files
------------

// File: rtl/program_run_checker_pkg.sv
// Shared types for the run-and-check controller.
package program_run_checker_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReset = 3'd1,
        StRun   = 3'd2,
        StScan  = 3'd3,
        StDone  = 3'd4
    } prc_state_e;

endpackage

// File: rtl/program_run_checker_cycle_counter.sv
// Loadable down-counter with zero flag; times both the RESET and RUN phases.
module program_run_checker_cycle_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/program_run_checker.sv
// Holds the processor in reset, runs it for a set number of cycles, then scans and checks its GPRs.
module program_run_checker
    import program_run_checker_pkg::*;
#(
    parameter int unsigned  WIDTH        = 32,
    parameter int unsigned  NREGS        = 32,
    parameter int unsigned  FIRST_REG    = 1,
    parameter int unsigned  CW           = 16,
    parameter int unsigned  RESET_CYCLES = 2,
    localparam int unsigned IW           = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CW-1:0]    run_cycles_i,
    input  logic             stop_on_first_i,
    output logic             proc_reset_o,
    output logic [IW-1:0]    rf_addr_o,
    input  logic [WIDTH-1:0] rf_data_i,
    output logic [IW-1:0]    exp_addr_o,
    input  logic [WIDTH-1:0] exp_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [IW-1:0]    fail_idx_o,
    output logic [WIDTH-1:0] fail_actual_o,
    output logic [WIDTH-1:0] fail_expected_o,
    output logic [IW:0]      mismatch_count_o
);

    prc_state_e       state_q;
    logic [CW-1:0]    run_q;
    logic             stop_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    fail_idx_q;
    logic [WIDTH-1:0] fail_actual_q;
    logic [WIDTH-1:0] fail_expected_q;
    logic [IW:0]      count_q;
    logic             proc_reset_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             mismatch;
    logic             cnt_load;
    logic [CW-1:0]    cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign accept   = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign mismatch = (rf_data_i != exp_data_i);

    // Counter holds "cycles remaining minus one", so a phase of length L loads L-1.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = CW'(RESET_CYCLES - 1);
        cnt_dec      = 1'b0;
        if (accept) begin
            cnt_load = 1'b1;
        end else if ((state_q == StReset) && cnt_zero && (run_q != '0)) begin
            cnt_load     = 1'b1;
            cnt_load_val = run_q - CW'(1);
        end else if ((state_q == StReset) || (state_q == StRun)) begin
            cnt_dec = 1'b1;
        end
    end

    program_run_checker_cycle_counter #(
        .W (CW)
    ) u_cycle_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            run_q           <= '0;
            stop_q          <= 1'b0;
            idx_q           <= IW'(FIRST_REG);
            fail_idx_q      <= '0;
            fail_actual_q   <= '0;
            fail_expected_q <= '0;
            count_q         <= '0;
            proc_reset_q    <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q         <= StReset;
                        run_q           <= run_cycles_i;
                        stop_q          <= stop_on_first_i;
                        idx_q           <= IW'(FIRST_REG);
                        fail_idx_q      <= '0;
                        fail_actual_q   <= '0;
                        fail_expected_q <= '0;
                        count_q         <= '0;
                        proc_reset_q    <= 1'b1;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                    end
                end
                StReset: begin
                    if (cnt_zero) begin
                        if (run_q == '0) begin
                            state_q <= StScan;
                        end else begin
                            state_q      <= StRun;
                            proc_reset_q <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (cnt_zero) begin
                        state_q      <= StScan;
                        proc_reset_q <= 1'b1;
                    end
                end
                StScan: begin
                    if (mismatch) begin
                        count_q <= count_q + (IW + 1)'(1);
                        if (count_q == '0) begin
                            fail_idx_q      <= idx_q;
                            fail_actual_q   <= rf_data_i;
                            fail_expected_q <= exp_data_i;
                        end
                    end
                    if ((idx_q == IW'(NREGS - 1)) || (stop_q && mismatch)) begin
                        state_q <= StDone;
                        idx_q   <= IW'(FIRST_REG);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    proc_reset_q <= 1'b1;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign proc_reset_o     = proc_reset_q;
    assign rf_addr_o        = idx_q;
    assign exp_addr_o       = idx_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = done_q && (count_q == '0);
    assign fail_idx_o       = fail_idx_q;
    assign fail_actual_o    = fail_actual_q;
    assign fail_expected_o  = fail_expected_q;
    assign mismatch_count_o = count_q;

endmodule
